ha_result_checker: RTL

- Receive-side companion to the pipelined half adder. It samples each (A,B) operand pair the adder is fed and predicts S=A^B, cout=A&B.
- It compares the adder's {cout,S} against that prediction exactly LATENCY clocks later and accumulates pass/fail statistics.
- Synthesizable. Sits beside the adder in on-chip self-test and in simulation benches, driven from the same clk.

---
 rtl/ha_result_checker.sv | 113 +++++++++++
 1 files changed

// File: rtl/ha_result_checker.sv
// Scores a pipelined half adder: predicts {A&B, A^B} for each sampled operand
// pair and compares against the adder's {cout,S} exactly LATENCY clocks later.
//
// state | meaning
// IDLE  | nothing in flight, waiting for the first en
// RUN   | operand pairs in flight or still arriving
// HALT  | frozen after a mismatch (STOP_ON_ERR=1), left only by clear or rst
module ha_result_checker #(
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             A,
  input  logic             B,
  input  logic             S,
  input  logic             cout,
  input  logic             clear,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic             mismatch,
  output logic             err_seen,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             halted,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [LATENCY-1:0] v_q, s_q, c_q;
  logic [LATENCY-1:0] v_d, s_d, c_d;
  logic               halt_st, tail_hit, tail_bad;

  // Stage 0 takes the new pair; the tail stage is the one being scored this edge.
  always_comb begin
    v_d    = '0;
    s_d    = '0;
    c_d    = '0;
    v_d[0] = en;
    s_d[0] = A ^ B;
    c_d[0] = A & B;
    for (int i = 1; i < LATENCY; i++) begin
      v_d[i] = v_q[i-1];
      s_d[i] = s_q[i-1];
      c_d[i] = c_q[i-1];
    end
  end

  assign halt_st  = (state_q == ST_HALT);
  assign tail_hit = v_q[LATENCY-1] && !halt_st;
  assign tail_bad = tail_hit && ({cout, S} != {c_q[LATENCY-1], s_q[LATENCY-1]});
  assign busy     = |v_q;
  assign halted   = halt_st;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en && !(|v_d)) state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (STOP_ON_ERR && tail_bad) state_d = ST_HALT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      v_q           <= '0;
      s_q           <= '0;
      c_q           <= '0;
      check_count   <= '0;
      err_count     <= '0;
      mismatch      <= 1'b0;
      err_seen      <= 1'b0;
      first_err_idx <= '0;
    end else if (clear) begin
      state_q       <= ST_IDLE;
      v_q           <= '0;
      s_q           <= '0;
      c_q           <= '0;
      check_count   <= '0;
      err_count     <= '0;
      mismatch      <= 1'b0;
      err_seen      <= 1'b0;
      first_err_idx <= '0;
    end else if (!halt_st) begin
      state_q  <= state_d;
      v_q      <= v_d;
      s_q      <= s_d;
      c_q      <= c_d;
      mismatch <= tail_bad;
      if (tail_hit && (check_count != CNT_MAX)) check_count <= check_count + CNT_ONE;
      // A saturated err_count still lets the mismatch pulse through.
      if (tail_bad) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
        err_seen <= 1'b1;
        if (!err_seen) first_err_idx <= check_count;
      end
    end else begin
      mismatch <= 1'b0;
    end
  end

endmodule
